addsub_seq_ctrl: RTL and testbench
==================================

# addsub_seq_ctrl

Nibble-serial add/subtract sequencer. It accepts one WIDTH-bit add or subtract request and computes it four bits per cycle on a single internal 4-bit add/sub slice, carrying between slices through a register. It reports signed overflow, zero and negative flags. It sits beside the ALU as a low-area arithmetic path: software-visible flag semantics match the 4-bit adder's signed overflow rules, extended to WIDTH bits.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4, ≥ 8. N = WIDTH/4 nibble steps.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request strobe; accepted only in IDLE.
- A  input  WIDTH  signed operand A; sampled on the accepting edge.
- B  input  WIDTH  signed operand B; sampled on the accepting edge.
- sub  input  1  1 = A − B, 0 = A + B; sampled with A and B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags are valid.
- Sum  output  WIDTH  result, two's complement wrap.
- Ovfl  output  1  signed overflow of the full-width operation.
- Zero  output  1  Sum == 0.
- Neg  output  1  Sum[WIDTH-1].

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE.
- Reset values: busy=0, done=0, Sum=0, Ovfl=0, Zero=0, Neg=0; step counter=0; carry=0.
- IDLE with start=1: latch A, B and sub; set carry=sub; clear counter k to 0; go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, step k:
  - Compute nibble k as A[4k+3:4k] + (B[4k+3:4k] ^ {4{sub}}) + carry.
  - Write the 4-bit result into Sum[4k+3:4k] and store carry-out into carry.
  - Increment k.
- Last step (k = N−1): Ovfl = carry-in to bit WIDTH−1 XOR carry-out of bit WIDTH−1. Equivalent check: addition overflows when A and B have the same sign and Sum has a different sign; subtraction overflows when A and B differ in sign and Sum's sign equals B's sign. After this step, go to DONE.
- DONE: done=1 for exactly one cycle; Zero and Neg reflect the final Sum; return to IDLE.
- Sum is built in place. Intermediate nibbles are visible during RUN, but Sum is only meaningful when done=1.
- Sum and all flags hold their values after DONE until the next accepted start.
- An accepted start clears Ovfl, Zero and Neg on the accepting edge.
- start in RUN or DONE is ignored, not queued. The operand registers do not change.
- Operand inputs may change freely after the accepting edge.
- Carry-out of the final nibble is discarded; the result wraps modulo 2^WIDTH.

## Timing
- Cycle t: IDLE and start=1.
- Cycles t+1 … t+N: RUN with busy=1 (N cycles).
- Cycle t+N+1: DONE with done=1, busy=0.
- Cycle t+N+2: IDLE; earliest cycle a new start is accepted.
- Throughput is one operation per N+2 cycles. WIDTH=16 gives 4 RUN cycles, with done in cycle t+5.
- rst=1 at any edge, including mid-RUN or in DONE: next cycle is IDLE with all outputs at their reset values. No done pulse is produced for the aborted operation.
- rst and start high at the same edge: rst wins and start is dropped.
- busy and done are never high in the same cycle.

## Test plan
- 0x00FF + 0x0001 (sub=0), checking carry ripple across nibbles → done at t+5; Sum=0x0100, Ovfl=0, Zero=0, Neg=0; busy high exactly cycles t+1..t+4.
- 0x7FFF + 0x0001 → Sum=0x8000, Ovfl=1, Neg=1. Follow with 0x8000 + 0xFFFF → Sum=0x7FFF, Ovfl=1, Neg=0.
- 0x1234 − 0x1234 → Sum=0x0000, Zero=1, Ovfl=0. Then 0x8000 − 0x0001 → Sum=0x7FFF, Ovfl=1. Then 0x0003 − 0x0005 → Sum=0xFFFE, Neg=1, Ovfl=0.
- start pulsed with different operands at t+2 and t+5 → both ignored; the first result is unchanged and done pulses once. A start at t+6 is accepted.
- rst asserted at t+3 mid-RUN → at t+4 state is IDLE, all outputs are 0, and no done follows. A fresh 0x0001 + 0x0001 then yields Sum=0x0002.
- 1000 random operand/sub pairs, compared against a 17-bit golden model → Sum, Ovfl, Zero and Neg all match, and done is always exactly N+1 cycles after start.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one WIDTH-bit add or subtract computed
// four bits per cycle on a single 4-bit slice, with signed overflow, zero and negative flags.
module addsub_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);
    // state  | meaning
    // IDLE   | waiting for start; results and flags hold
    // RUN    | one nibble per cycle, k = 0 .. N-1
    // DONE   | one-cycle done pulse, results valid
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovfl_q, ovfl_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] lo3;
    logic [4:0] nib_sum;

    always_comb begin
        nib_a   = a_q[4*k_q +: 4];
        nib_b   = b_q[4*k_q +: 4] ^ {4{sub_q}};
        // lo3[3] is the carry into the nibble's top bit, needed for overflow
        lo3     = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
        nib_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub;
                    carry_d = sub;
                    k_d     = '0;
                    ovfl_d  = 1'b0;
                    zero_d  = 1'b0;
                    neg_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[4*k_q +: 4] = nib_sum[3:0];
                carry_d           = nib_sum[4];
                k_d               = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    ovfl_d  = lo3[3] ^ nib_sum[4];
                    zero_d  = (sum_d == '0);
                    neg_d   = sum_d[WIDTH-1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: a cycle-level behavioural model built
// from plain 17-bit arithmetic, checked every cycle, plus directed literal cases.
module tb_addsub_seq_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         sub = 1'b0;
    logic         busy, done, Ovfl, Zero, Neg;
    logic [W-1:0] Sum;

    int checks = 0;
    int failures = 0;

    addsub_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sub(sub),
        .busy(busy), .done(done), .Sum(Sum), .Ovfl(Ovfl), .Zero(Zero), .Neg(Neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] sm, output logic ov,
                                   output logic z, output logic n);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b};
        sm = r[W-1:0];
        if (s) ov = (a[W-1] != b[W-1]) && (sm[W-1] == b[W-1]);
        else   ov = (a[W-1] == b[W-1]) && (sm[W-1] != a[W-1]);
        z = (sm == '0);
        n = sm[W-1];
    endfunction

    // Model: phase 0 = idle, 1..N = running, N+1 = done cycle.
    int           phase = 0;
    bit           m_started = 0;
    bit           sum_known = 0;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic         m_ov = 0, m_z = 0, m_n = 0, p_ov = 0, p_z = 0, p_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1; phase = 0; sum_known = 1;
            m_sum = '0; m_ov = 0; m_z = 0; m_n = 0;
        end else if (phase == 0) begin
            if (start) begin
                golden(A, B, sub, p_sum, p_ov, p_z, p_n);
                phase = 1; sum_known = 0;
                m_ov = 0; m_z = 0; m_n = 0;
            end
        end else if (phase <= N) begin
            phase++;
            if (phase == N + 1) begin
                m_sum = p_sum; m_ov = p_ov; m_z = p_z; m_n = p_n; sum_known = 1;
            end
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("busy", 32'(busy), 32'(phase >= 1 && phase <= N));
            chk("done", 32'(done), 32'(phase == N + 1));
            if (sum_known) chk("sum", 32'(Sum), 32'(m_sum));
            if (phase == 0 || phase == N + 1) begin
                chk("ovfl", 32'(Ovfl), 32'(m_ov));
                chk("zero", 32'(Zero), 32'(m_z));
                chk("neg", 32'(Neg), 32'(m_n));
            end
        end
    end

    // Accept one op, then wait (bounded) for done; returns positioned at the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit lit, input logic [W-1:0] e_sum, input logic e_ov,
                          input logic e_z, input logic e_n);
        int waited;
        bit seen;
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
        seen = 0;
        waited = 1;
        for (int i = 0; i < N + 6; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
            waited++;
        end
        if (!seen) chk("done_timeout", 32'(0), 32'(1));
        else chk("done_latency", 32'(waited), 32'(N + 1));
        if (lit) begin
            chk("lit_sum", 32'(Sum), 32'(e_sum));
            chk("lit_ovfl", 32'(Ovfl), 32'(e_ov));
            chk("lit_zero", 32'(Zero), 32'(e_z));
            chk("lit_neg", 32'(Neg), 32'(e_n));
            chk("model_sum", 32'(m_sum), 32'(e_sum));
            chk("model_ovfl", 32'(m_ov), 32'(e_ov));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sum", 32'(Sum), 32'(0));
        chk("rst_busy_done", 32'({busy, done}), 32'(0));
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1, 0, 1);
        run_op(16'h8000, 16'hFFFF, 1'b0, 1, 16'h7FFF, 1, 0, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 1, 16'h0000, 0, 1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1, 0, 0);
        run_op(16'h0003, 16'h0005, 1'b1, 1, 16'hFFFE, 0, 0, 1);

        // starts during RUN and DONE are ignored; start right after DONE is accepted
        @(negedge clk); A = 16'h1111; B = 16'h2222; sub = 0; start = 1;   // t
        @(negedge clk); start = 0;                                       // t+1
        @(negedge clk); A = 16'h7FFF; B = 16'h7FFF; start = 1;           // t+2
        @(negedge clk); start = 0;                                       // t+3
        @(negedge clk);                                                  // t+4
        @(negedge clk); A = 16'h4444; start = 1;                         // t+5
        chk("ign_done", 32'(done), 32'(1));
        chk("ign_sum", 32'(Sum), 32'(16'h3333));
        @(negedge clk); A = 16'h0F0F; B = 16'h0010; sub = 1; start = 1;  // t+6
        @(negedge clk); start = 0;
        repeat (N) @(negedge clk);
        chk("after_ign_done", 32'(done), 32'(1));
        chk("after_ign_sum", 32'(Sum), 32'(16'h0EFF));

        // reset mid-RUN
        @(negedge clk); A = 16'hFFFF; B = 16'hFFFF; sub = 0; start = 1;  // t
        @(negedge clk); start = 0;                                       // t+1
        @(negedge clk);                                                  // t+2
        @(negedge clk); rst = 1;                                         // t+3
        @(negedge clk); rst = 0;                                         // t+4
        chk("abort_outputs", 32'({busy, done, Ovfl, Zero, Neg}), 32'(0));
        chk("abort_sum", 32'(Sum), 32'(0));
        repeat (8) @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 1, 16'h0002, 0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            rs = 1'($urandom);
            run_op(ra, rb, rs, 0, '0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
